// File: rtl/pmem_pkg.sv
// pmem_pkg: shared types and default window constants for the physical-memory
// arbiter. Holds the arbiter state encoding, the requester id used for the
// round-robin pointer and ownership, and the default memory window.
package pmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MREQ,
    MWAIT,
    RESP
  } state_t;

  typedef enum logic {
    REQ_IFU,
    REQ_LSU
  } req_id_t;

  localparam logic [31:0] MEM_BASE_DEF = 32'h8000_0000;
  localparam logic [31:0] MEM_SIZE_DEF = 32'h0800_0000;

endpackage

// File: rtl/pmem_addr_check.sv
// pmem_addr_check: combinational physical-memory window compare.
//   addr     in  32  byte address to test
//   in_range out 1   1 when BASE <= addr < BASE+SIZE
// The compare is done at 33 bits so a window touching 2^32 does not wrap.
module pmem_addr_check
  import pmem_pkg::*;
#(
  parameter logic [31:0] BASE = MEM_BASE_DEF,
  parameter logic [31:0] SIZE = MEM_SIZE_DEF
) (
  input  logic [31:0] addr,
  output logic        in_range
);

  logic [32:0] addr_x;
  logic [32:0] lo;
  logic [32:0] hi;

  assign addr_x   = {1'b0, addr};
  assign lo       = {1'b0, BASE};
  assign hi       = {1'b0, BASE} + {1'b0, SIZE};
  assign in_range = (addr_x >= lo) && (addr_x < hi);

endmodule

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares the single physical-memory port between the IFU and
// the LSU, one transaction at a time, round-robin on ties.
//   clock, reset (async, active-low)
//   ifu_req_*  / ifu_resp_*  : fetch request / response (valid/ready)
//   lsu_req_*  / lsu_resp_*  : load/store request / response (valid/ready)
//   mem_req_*  / mem_resp_*  : memory port; one response pulse per request
// Out-of-window addresses are answered locally with fault=1 and data 0.
module pmem_arbiter
  import pmem_pkg::*;
#(
  parameter logic [31:0] MEM_BASE = MEM_BASE_DEF,
  parameter logic [31:0] MEM_SIZE = MEM_SIZE_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_resp_inst,
  output logic        ifu_resp_fault,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_req_addr,
  input  logic        lsu_req_wen,
  input  logic [63:0] lsu_req_wdata,
  input  logic [7:0]  lsu_req_wmask,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [63:0] lsu_resp_rdata,
  output logic        lsu_resp_fault,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [63:0] mem_req_wdata,
  output logic [7:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_rdata
);

  state_t      state;
  req_id_t     last_grant;
  req_id_t     owner;
  logic [31:0] addr_q;
  logic        wen_q;
  logic [63:0] wdata_q;
  logic [7:0]  wmask_q;
  logic [63:0] rdata_q;
  logic        fault_q;

  logic        ifu_grant;
  logic        lsu_grant;
  logic        accept;
  logic [31:0] acc_addr;
  logic        acc_in_range;

  // Round-robin: on a tie the requester that did not win last time goes.
  always_comb begin
    ifu_grant = ifu_req_valid && (!lsu_req_valid || (last_grant == REQ_LSU));
    lsu_grant = lsu_req_valid && !ifu_grant;
  end

  assign ifu_req_ready = (state == IDLE) && ifu_grant;
  assign lsu_req_ready = (state == IDLE) && lsu_grant;
  assign accept        = ifu_req_ready || lsu_req_ready;
  assign acc_addr      = ifu_grant ? ifu_req_addr : lsu_req_addr;

  // The window check runs on the address being latched so its result is
  // available at the accept edge; it is the same value as the latched address.
  pmem_addr_check #(
    .BASE(MEM_BASE),
    .SIZE(MEM_SIZE)
  ) u_addr_check (
    .addr    (acc_addr),
    .in_range(acc_in_range)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      last_grant     <= REQ_LSU;
      owner          <= REQ_IFU;
      addr_q         <= '0;
      wen_q          <= 1'b0;
      wdata_q        <= '0;
      wmask_q        <= '0;
      rdata_q        <= '0;
      fault_q        <= 1'b0;
      mem_req_valid  <= 1'b0;
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            owner      <= ifu_grant ? REQ_IFU : REQ_LSU;
            last_grant <= ifu_grant ? REQ_IFU : REQ_LSU;
            addr_q     <= acc_addr;
            wen_q      <= lsu_grant && lsu_req_wen;
            wdata_q    <= lsu_grant ? lsu_req_wdata : '0;
            wmask_q    <= lsu_grant ? lsu_req_wmask : '0;
            rdata_q    <= '0;
            if (acc_in_range) begin
              fault_q       <= 1'b0;
              mem_req_valid <= 1'b1;
              state         <= MREQ;
            end else begin
              fault_q        <= 1'b1;
              ifu_resp_valid <= ifu_grant;
              lsu_resp_valid <= lsu_grant;
              state          <= RESP;
            end
          end
        end
        MREQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= MWAIT;
          end
        end
        MWAIT: begin
          if (mem_resp_valid) begin
            rdata_q        <= wen_q ? '0 : mem_resp_rdata;
            ifu_resp_valid <= (owner == REQ_IFU);
            lsu_resp_valid <= (owner == REQ_LSU);
            state          <= RESP;
          end
        end
        RESP: begin
          if ((ifu_resp_valid && ifu_resp_ready) || (lsu_resp_valid && lsu_resp_ready)) begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ifu_resp_inst  = addr_q[2] ? rdata_q[63:32] : rdata_q[31:0];
  assign ifu_resp_fault = fault_q && (owner == REQ_IFU);
  assign lsu_resp_rdata = rdata_q;
  assign lsu_resp_fault = fault_q && (owner == REQ_LSU);

  assign mem_req_addr  = {32'h0, addr_q};
  assign mem_req_wen   = wen_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: randomized and directed stimulus for pmem_arbiter, checked
// against a transaction-level model (grant order, window rule, expected data).
module tb_pmem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_fault;
  logic [31:0] ifu_req_addr, ifu_resp_inst;
  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_fault;
  logic [31:0] lsu_req_addr;
  logic [63:0] lsu_req_wdata, lsu_resp_rdata;
  logic [7:0]  lsu_req_wmask;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
  logic [63:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
  logic [7:0]  mem_req_wmask;

  pmem_arbiter #(
    .MEM_BASE(32'h8000_0000),
    .MEM_SIZE(32'h0800_0000)
  ) dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_resp_inst(ifu_resp_inst), .ifu_resp_fault(ifu_resp_fault),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_resp_rdata(lsu_resp_rdata), .lsu_resp_fault(lsu_resp_fault),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Memory contents: a fixed function of the aligned doubleword address.
  logic        ovr_en  = 1'b0;
  logic [63:0] ovr_val = '0;
  function automatic logic [63:0] mem_word(input logic [31:0] a);
    logic [31:0] al;
    al = {a[31:3], 3'b000};
    if (ovr_en) return ovr_val;
    return {al ^ 32'h5A5A_0F0F, al * 32'h9E37_79B1};
  endfunction

  function automatic logic in_window(input logic [31:0] a);
    return ({32'h0, a} >= 64'h8000_0000) && ({32'h0, a} < 64'h8800_0000);
  endfunction

  // ---------------- reference model / monitor (samples on negedge) ---------
  int          cyc = 0;
  bit          busy, last_lsu, m_lsu, m_wen, m_fault, m_macc, m_got, m_rv_seen;
  int          m_age;
  logic [31:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_wmask;
  int          ifu_acc_cnt = 0, lsu_acc_cnt = 0, mem_txns = 0, rv_seen = 0, mreq_wait = 0;
  int          acc_cyc, rv_cyc;
  logic [31:0] cap_inst;
  logic [63:0] cap_rdata, cap_maddr, cap_mwdata;
  logic        cap_fault, cap_mwen;
  logic [7:0]  cap_mwmask;
  bit          grant_log[$];
  bit          ifu_win, lsu_win, exp_mreq, resp_now, exp_ifu_rv, exp_lsu_rv, done;
  logic [63:0] exp_data, w;

  initial begin
    busy = 0; last_lsu = 1;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        busy = 0; last_lsu = 1;
        check("rst_ifu_req_ready", ifu_req_ready, 0);
        check("rst_lsu_req_ready", lsu_req_ready, 0);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_ifu_resp_valid", ifu_resp_valid, 0);
        check("rst_lsu_resp_valid", lsu_resp_valid, 0);
        check("rst_data", {ifu_resp_inst, 30'h0, ifu_resp_fault, lsu_resp_fault}, 0);
        check("rst_rdata", lsu_resp_rdata, 0);
      end else begin
        if (busy) m_age++;
        ifu_win = 0; lsu_win = 0;
        if (!busy) begin
          if (ifu_req_valid && lsu_req_valid) ifu_win = last_lsu;
          else ifu_win = ifu_req_valid;
          lsu_win = lsu_req_valid && !ifu_win;
        end
        check("ifu_req_ready", ifu_req_ready, ifu_win);
        check("lsu_req_ready", lsu_req_ready, lsu_win);

        exp_mreq = busy && (m_age >= 1) && !m_fault && !m_macc;
        check("mem_req_valid", mem_req_valid, exp_mreq);
        if (exp_mreq) begin
          check("mem_req_addr", mem_req_addr, {32'h0, m_addr});
          check("mem_req_wen", mem_req_wen, m_wen);
          check("mem_req_wmask", mem_req_wmask, m_wmask);
          if (m_lsu) check("mem_req_wdata", mem_req_wdata, m_wdata);
          if (!mem_req_ready) mreq_wait++;
        end

        resp_now   = busy && (m_age >= 1) && (m_fault || m_got);
        exp_ifu_rv = resp_now && !m_lsu;
        exp_lsu_rv = resp_now && m_lsu;
        check("ifu_resp_valid", ifu_resp_valid, exp_ifu_rv);
        check("lsu_resp_valid", lsu_resp_valid, exp_lsu_rv);
        w = mem_word(m_addr);
        if (m_fault) exp_data = '0;
        else if (m_lsu) exp_data = m_wen ? 64'h0 : w;
        else exp_data = m_addr[2] ? {32'h0, w[63:32]} : {32'h0, w[31:0]};
        if (exp_ifu_rv) begin
          check("ifu_resp_inst", ifu_resp_inst, exp_data);
          check("ifu_resp_fault", ifu_resp_fault, m_fault);
        end
        if (exp_lsu_rv) begin
          check("lsu_resp_rdata", lsu_resp_rdata, exp_data);
          check("lsu_resp_fault", lsu_resp_fault, m_fault);
        end

        if (ifu_resp_valid || lsu_resp_valid) begin
          rv_seen++;
          if (busy && !m_rv_seen) begin m_rv_seen = 1; rv_cyc = cyc; end
        end
        if (busy && m_macc && !m_got && mem_resp_valid) m_got = 1;
        if (mem_req_valid && mem_req_ready) begin
          mem_txns++;
          cap_maddr = mem_req_addr; cap_mwen = mem_req_wen;
          cap_mwdata = mem_req_wdata; cap_mwmask = mem_req_wmask;
          if (exp_mreq) m_macc = 1;
        end
        done = (exp_ifu_rv && ifu_resp_ready) || (exp_lsu_rv && lsu_resp_ready);
        if (done) begin
          busy = 0;
          cap_inst = ifu_resp_inst; cap_rdata = lsu_resp_rdata;
          cap_fault = m_lsu ? lsu_resp_fault : ifu_resp_fault;
        end
        if (ifu_win || lsu_win) begin
          busy = 1; m_age = 0; m_lsu = lsu_win;
          m_addr  = lsu_win ? lsu_req_addr : ifu_req_addr;
          m_wen   = lsu_win && lsu_req_wen;
          m_wdata = lsu_req_wdata;
          m_wmask = lsu_win ? lsu_req_wmask : 8'h00;
          m_fault = !in_window(m_addr);
          m_macc = 0; m_got = 0; m_rv_seen = 0;
          last_lsu = lsu_win;
          grant_log.push_back(lsu_win);
          if (lsu_win) lsu_acc_cnt++; else ifu_acc_cnt++;
          acc_cyc = cyc;
        end
      end
    end
  end

  // ---------------- memory responder --------------------------------------
  int          dly_min = 1, dly_max = 1, stall_until = 0;
  bit          mem_rand = 0;
  int          seen_txns = 0, resp_cnt = 0;
  logic [31:0] pend;

  initial begin
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
    forever begin
      @(posedge clock); #1;
      mem_resp_valid = 0;
      mem_resp_rdata = {$urandom, $urandom};
      if (mem_txns != seen_txns) begin
        seen_txns = mem_txns;
        resp_cnt  = $urandom_range(dly_max, dly_min);
        pend      = cap_maddr[31:0];
      end
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_resp_valid = 1;
          mem_resp_rdata = mem_word(pend);
        end
      end
      mem_req_ready = (cyc < stall_until) ? 1'b0 : (mem_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // ---------------- requester driving --------------------------------------
  int ifu_seen = 0, lsu_seen = 0;
  bit rr_rand = 0, lsu_rr_block = 0;

  task automatic tick();
    @(posedge clock); #1;
    if (ifu_acc_cnt != ifu_seen) begin
      ifu_seen = ifu_acc_cnt; ifu_req_valid = 0; ifu_req_addr = $urandom;
    end
    if (lsu_acc_cnt != lsu_seen) begin
      lsu_seen = lsu_acc_cnt; lsu_req_valid = 0; lsu_req_addr = $urandom;
    end
    ifu_resp_ready = rr_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    lsu_resp_ready = lsu_rr_block ? 1'b0 : (rr_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
  endtask

  task automatic issue_ifu(input logic [31:0] a);
    ifu_req_valid = 1; ifu_req_addr = a;
  endtask

  task automatic issue_lsu(input logic [31:0] a, input logic we, input logic [63:0] d, input logic [7:0] m);
    lsu_req_valid = 1; lsu_req_addr = a; lsu_req_wen = we; lsu_req_wdata = d; lsu_req_wmask = m;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin tick(); n++; end
    while ((busy || ifu_req_valid || lsu_req_valid) && n < budget);
    if (busy || ifu_req_valid || lsu_req_valid) check("timeout_wait_done", 1, 0);
  endtask

  task automatic do_reset();
    reset = 0; tick(); tick(); reset = 1; tick();
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned s;
    s = $urandom_range(0, 9);
    case (s)
      0: return 32'h7FFF_FFFC;
      1: return 32'h8800_0000;
      2: return 32'h87FF_FFFC;
      3: return $urandom;
      default: return 32'h8000_0000 | ($urandom & 32'h07FF_FFFC);
    endcase
  endfunction

  int          g0, n0, r0, wq0, k;
  logic [63:0] wexp;

  initial begin
    ifu_req_valid = 0; ifu_req_addr = '0; ifu_resp_ready = 0;
    lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wen = 0; lsu_req_wdata = '0; lsu_req_wmask = '0;
    lsu_resp_ready = 0;
    reset = 0;
    repeat (3) tick();
    reset = 1; tick();

    // fetch with minimum latency, upper half of the doubleword
    ovr_en = 1; ovr_val = 64'h1111_2222_3333_4444;
    issue_ifu(32'h8000_0004); wait_done(50);
    check("t1_inst", cap_inst, 32'h1111_2222);
    check("t1_fault", cap_fault, 0);
    check("t1_latency", rv_cyc - acc_cyc, 3);
    ovr_en = 0;

    // round-robin alternation after reset
    do_reset();
    g0 = grant_log.size();
    issue_ifu(32'h8000_0100); issue_lsu(32'h8000_0200, 0, '0, '0); wait_done(100);
    issue_ifu(32'h8000_0108); issue_lsu(32'h8000_0208, 0, '0, '0); wait_done(100);
    check("t2_grant_count", grant_log.size() - g0, 4);
    if (grant_log.size() >= g0 + 4) begin
      check("t2_grant0_ifu", grant_log[g0], 0);
      check("t2_grant1_lsu", grant_log[g0+1], 1);
      check("t2_grant2_ifu", grant_log[g0+2], 0);
    end

    // store: payload forwarded unchanged, rdata 0
    n0 = mem_txns;
    issue_lsu(32'h8000_0010, 1, 64'hDEAD_BEEF_0000_0001, 8'h0F); wait_done(50);
    check("t3_txns", mem_txns - n0, 1);
    check("t3_addr", cap_maddr, 64'h8000_0010);
    check("t3_wen", cap_mwen, 1);
    check("t3_wdata", cap_mwdata, 64'hDEAD_BEEF_0000_0001);
    check("t3_wmask", cap_mwmask, 8'h0F);
    check("t3_rdata", cap_rdata, 0);
    check("t3_fault", cap_fault, 0);

    // out-of-window on both requesters, then last in-window doubleword
    n0 = mem_txns;
    issue_ifu(32'h0000_0000); wait_done(50);
    check("t4_ifu_fault", cap_fault, 1);
    check("t4_ifu_inst", cap_inst, 0);
    check("t4_fault_latency", rv_cyc - acc_cyc, 1);
    issue_lsu(32'h8800_0000, 0, '0, '0); wait_done(50);
    check("t4_lsu_fault", cap_fault, 1);
    check("t4_lsu_rdata", cap_rdata, 0);
    check("t4_no_mem", mem_txns - n0, 0);
    issue_lsu(32'h87FF_FFF8, 0, '0, '0); wait_done(50);
    check("t4_top_fault", cap_fault, 0);
    check("t4_top_rdata", cap_rdata, mem_word(32'h87FF_FFF8));
    check("t4_top_mem", mem_txns - n0, 1);

    // memory stall then response backpressure
    n0 = mem_txns; wq0 = mreq_wait;
    stall_until = cyc + 7; lsu_rr_block = 1;
    issue_lsu(32'h8000_0040, 0, '0, '0);
    k = 0;
    while (!lsu_resp_valid && k < 50) begin tick(); k++; end
    check("t5_resp_arrived", lsu_resp_valid, 1);
    repeat (4) tick();
    lsu_rr_block = 0; wait_done(50);
    check("t5_stall_cycles", (mreq_wait - wq0) >= 5, 1);
    check("t5_txns", mem_txns - n0, 1);
    check("t5_rdata", cap_rdata, mem_word(32'h8000_0040));

    // reset during MWAIT, stale response afterwards
    dly_min = 6; dly_max = 6;
    n0 = mem_txns;
    issue_lsu(32'h8000_0080, 0, '0, '0);
    k = 0;
    while (mem_txns == n0 && k < 20) begin tick(); k++; end
    check("t6_reached_mem", mem_txns - n0, 1);
    tick();
    reset = 0; tick(); reset = 1;
    r0 = rv_seen;
    repeat (10) tick();
    check("t6_no_resp", rv_seen - r0, 0);
    check("t6_no_mem", mem_txns - n0, 1);
    dly_min = 1; dly_max = 1;
    issue_ifu(32'h8000_0008); wait_done(50);
    wexp = mem_word(32'h8000_0008);
    check("t6_after_inst", cap_inst, wexp[31:0]);
    check("t6_after_fault", cap_fault, 0);

    // randomized traffic
    mem_rand = 1; rr_rand = 1; dly_min = 1; dly_max = 3;
    repeat (1500) begin
      tick();
      if (!ifu_req_valid && $urandom_range(0, 2) == 0) issue_ifu(rand_addr());
      if (!lsu_req_valid && $urandom_range(0, 2) == 0)
        issue_lsu(rand_addr(), $urandom_range(0, 1) == 1, {$urandom, $urandom}, 8'($urandom));
    end
    mem_rand = 0; rr_rand = 0;
    wait_done(200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
